mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/mem_resp_ram.sv | 41 ++++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared constants for the memory responder slice: data width, wait-state
// counter width and the FSM state encoding used by mem_responder.
// No ports (package only).
// ---------------------------------------------------------------------------
package mem_resp_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // FSM encoding kept as plain constants so older tooling can share it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_resp_ram.sv
// ---------------------------------------------------------------------------
// mem_resp_ram
// Single-port word storage with one write port and a registered read.
// Read-before-write on a shared address: rdata returns the old contents,
// which is fine because the responder never returns read data for a write.
// The array has no reset so it maps onto block RAM.
//
// Ports:
//   clk    in   clock
//   en     in   access enable (read capture and optional write)
//   we     in   write enable, qualified by en
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, updates only when en=1
// ---------------------------------------------------------------------------
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder. A request is accepted in IDLE,
// optionally delayed WAIT_CYCLES cycles in WAIT, then the storage access
// happens on the edge entering RESP, where the response is held until the
// initiator takes it.
//
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to reject requests whose
// req_addr[1:0] is non-zero (no storage write, rsp_err=1, rsp_rdata=0).
// Without it the low address bits are ignored and rsp_err is always 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high only in IDLE (and not in reset)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address, wraps modulo DEPTH*4
//   req_wdata  in   write data
//   rsp_valid  out  response present (RESP state)
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  read data, 0 for writes and errored requests
//   rsp_err    out  alignment error flag
// ---------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [AW+1:0]     addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              rdata_en_reg;

  logic              accept;
  logic              enter_resp;
  logic              sel_we;
  logic [AW+1:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;
  logic [DATA_W-1:0] ram_rdata;

  // Address bits above the word index are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = (state_reg == ST_IDLE) && reset;
  assign rsp_valid = (state_reg == ST_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the storage access happens on the accept edge
  // itself, so the live request fields are used instead of the latched copy.
  assign sel_we    = (state_reg == ST_IDLE) ? req_we    : we_reg;
  assign sel_addr  = (state_reg == ST_IDLE) ? req_addr[AW+1:0] : addr_reg;
  assign sel_wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign sel_bad = (sel_addr[1:0] != 2'b00);
`else
  assign sel_bad = 1'b0;
`endif

  // Gated by reset so a write still in flight at reset never commits.
  assign enter_resp = reset &&
                      (((state_reg == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state_reg == ST_WAIT) && (cnt_reg == CNT_ONE)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      rdata_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (enter_resp) begin
        rdata_en_reg <= !sel_we && !sel_bad;
      end
    end
  end

  // Request fields need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr[AW+1:0];
      wdata_reg <= req_wdata;
    end
  end

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (enter_resp),
    .we    (sel_we && !sel_bad),
    .addr  (sel_addr[AW+1:2]),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register holds its value until the next access, so the
  // response data stays stable in RESP; gating forces 0 elsewhere.
  assign rsp_rdata = (rsp_valid && rdata_en_reg) ? ram_rdata : '0;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic err_reg;
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (enter_resp) begin
      err_reg <= sel_bad;
    end
  end
  assign rsp_err = rsp_valid && err_reg;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
